// File: rtl/complex_pkg.sv
// Shared types and helpers for the complex adder datapath.
// Complex words are packed {re, im}, each component CPLX_W bits.
package complex_pkg;

  localparam int CPLX_W = 32;

  typedef struct packed {
    logic [CPLX_W-1:0] re;
    logic [CPLX_W-1:0] im;
  } cplx_t;

  // Components wrap independently; no carry from im into re.
  function automatic cplx_t cplx_add(cplx_t a, cplx_t b);
    cplx_t s;
    s.re = a.re + b.re;
    s.im = a.im + b.im;
    return s;
  endfunction

endpackage

// File: rtl/complex_add_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans from rr_ptr upward, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [TAG_W-1:0]   idx,
  output logic               any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (int'(rr_ptr) + k) % NUM_REQ;
        if (!any && req[j]) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          idx    = TAG_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/complex_add_arbiter.sv
// Shared registered complex adder behind a round-robin arbiter,
// with a valid/ready result stage tagged by requester index.
module complex_add_arbiter
  import complex_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = CPLX_W,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*2*W-1:0] req_a,
  input  logic [NUM_REQ*2*W-1:0] req_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*W-1:0]         out_sum,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] gidx;
  logic [TAG_W-1:0] ptr_nxt;
  logic             any;
  logic             free;
  logic [2*W-1:0]   a_g;
  logic [2*W-1:0]   b_g;
  logic [2*W-1:0]   sum_g;

  assign free = !out_valid || out_ready;

  // Gated by rst_n so nothing is accepted while reset is held.
  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TAG_W  (TAG_W)
  ) u_arb (
    .req   (req_valid),
    .rr_ptr(rr_ptr),
    .enable(free && rst_n),
    .gnt   (req_ready),
    .idx   (gidx),
    .any   (any)
  );

  assign a_g = req_a[int'(gidx)*2*W +: 2*W];
  assign b_g = req_b[int'(gidx)*2*W +: 2*W];

  generate
    if (W == CPLX_W) begin : g_pkg_add
      assign sum_g = cplx_add(a_g, b_g);
    end else begin : g_gen_add
      assign sum_g = {a_g[2*W-1:W] + b_g[2*W-1:W],
                      a_g[W-1:0] + b_g[W-1:0]};
    end
  endgenerate

  assign ptr_nxt = (gidx == TAG_W'(NUM_REQ-1)) ?
                   '0 : gidx + TAG_W'(1);

  assign busy = out_valid || (|req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tag   <= '0;
      rr_ptr    <= '0;
    end else if (any) begin
      out_valid <= 1'b1;
      out_sum   <= sum_g;
      out_tag   <= gidx;
      rr_ptr    <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_complex_add_arbiter.sv
// Self-checking bench for complex_add_arbiter.
// Directed scenarios plus randomized traffic against a reference model.
module tb_complex_add_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*2*W-1:0] req_a;
  logic [N*2*W-1:0] req_b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_sum;
  logic [TW-1:0]    out_tag;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;

  int           m_ptr;
  bit           m_ov;
  logic [63:0]  m_sum;
  int           m_tag;

  complex_add_arbiter #(.NUM_REQ(N), .W(W), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_grant(logic [N-1:0] v, int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    if (!rst_n || (m_ov && !out_ready)) return r;
    g = ref_grant(req_valid, m_ptr);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] ref_sum(logic [63:0] a, logic [63:0] b);
    logic [63:0] re;
    logic [63:0] im;
    re = (64'(a[63:32]) + 64'(b[63:32])) % 64'h1_0000_0000;
    im = (64'(a[31:0]) + 64'(b[31:0])) % 64'h1_0000_0000;
    return {re[31:0], im[31:0]};
  endfunction

  task automatic set_op(int i, logic [31:0] ar, logic [31:0] ai,
                        logic [31:0] br, logic [31:0] bi);
    req_a[i*2*W +: 2*W] = {ar, ai};
    req_b[i*2*W +: 2*W] = {br, bi};
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    m_sum = '0;
    m_tag = 0;
  endtask

  // Advance one clock edge and update the model; g is the granted index or -1.
  task automatic tick(output int g);
    g = -1;
    if (rst_n && (!m_ov || out_ready)) g = ref_grant(req_valid, m_ptr);
    @(posedge clk);
    if (g >= 0) begin
      m_sum = ref_sum(req_a[g*2*W +: 2*W], req_b[g*2*W +: 2*W]);
      m_tag = g;
      m_ov  = 1'b1;
      m_ptr = (g + 1) % N;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (req_ready !== '0) begin
      mismatched++;
      $display("FAIL reset_ready_in_reset: got %b want 0000", req_ready);
    end
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_tag !== '0) begin
      mismatched++;
      $display("FAIL reset_out: got v=%b s=%h t=%0d want 0/0/0",
               out_valid, out_sum, out_tag);
    end
    compared++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: got rdy=%b busy=%b want 0000/0",
               req_ready, busy);
    end
  endtask

  task automatic test_single();
    int g;
    do_reset();
    set_op(0, 10, 14, 8, 9);
    req_valid = 4'b0001;
    #1;
    compared++;
    if (req_ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    tick(g);
    req_valid = '0;
    compared++;
    if (out_valid !== 1'b1 || out_sum !== {32'd18, 32'd23} ||
        out_tag !== 2'd0) begin
      mismatched++;
      $display("FAIL single_out: got v=%b s=%h t=%0d want 1/%h/0",
               out_valid, out_sum, out_tag, {32'd18, 32'd23});
    end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, i, i, 1, 1);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      tick(g);
      compared++;
      if (out_valid !== 1'b1 || int'(out_tag) !== k % N ||
          out_sum[63:32] !== 32'(out_tag) + 32'd1) begin
        mismatched++;
        $display("FAIL rr_step%0d: got v=%b t=%0d re=%0d want 1/%0d/%0d",
                 k, out_valid, out_tag, out_sum[63:32], k % N, k % N + 1);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int g;
    logic [63:0] hs;
    logic [TW-1:0] ht;
    do_reset();
    set_op(0, 5, 6, 7, 8);
    set_op(1, $urandom, $urandom, $urandom, $urandom);
    set_op(2, $urandom, $urandom, $urandom, $urandom);
    req_valid = 4'b0001;
    tick(g);
    hs = out_sum;
    ht = out_tag;
    out_ready = 1'b0;
    req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      compared++;
      if (req_ready !== '0 || out_valid !== 1'b1 ||
          out_sum !== hs || out_tag !== ht) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b s=%h t=%0d want 0000/1/%h/%0d",
                 k, req_ready, out_valid, out_sum, out_tag, hs, ht);
      end
      tick(g);
    end
    out_ready = 1'b1;
    #1;
    compared++;
    if (req_ready !== 4'b0010) begin
      mismatched++;
      $display("FAIL bp_release_ready: got %b want 0010", req_ready);
    end
    tick(g);
    compared++;
    if (out_tag !== 2'd1 || out_sum !== m_sum) begin
      mismatched++;
      $display("FAIL bp_tag1: got t=%0d s=%h want 1/%h", out_tag, out_sum, m_sum);
    end
    req_valid = 4'b0100;
    tick(g);
    compared++;
    if (out_tag !== 2'd2 || out_sum !== m_sum) begin
      mismatched++;
      $display("FAIL bp_tag2: got t=%0d s=%h want 2/%h", out_tag, out_sum, m_sum);
    end
    hs = m_sum;
    req_valid = '0;
    tick(g);
    compared++;
    if (out_valid !== 1'b0 || out_tag !== 2'd2 || out_sum !== hs) begin
      mismatched++;
      $display("FAIL bp_drain: got v=%b t=%0d s=%h want 0/2/%h",
               out_valid, out_tag, out_sum, hs);
    end
  endtask

  task automatic test_wrap();
    int g;
    do_reset();
    set_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 2);
    req_valid = 4'b0001;
    tick(g);
    req_valid = '0;
    compared++;
    if (out_sum !== 64'h00000000_00000001) begin
      mismatched++;
      $display("FAIL wrap_sum: got %h want 0000000000000001", out_sum);
    end
  endtask

  task automatic test_pointer_skip();
    int g;
    do_reset();
    req_valid = 4'b0010;
    tick(g);
    req_valid = 4'b0001;
    #1;
    compared++;
    if (req_ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL skip_ready: got %b want 0001", req_ready);
    end
    tick(g);
    compared++;
    if (out_tag !== 2'd0) begin
      mismatched++;
      $display("FAIL skip_grant0: got %0d want 0", out_tag);
    end
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      tick(g);
      compared++;
      if (int'(out_tag) !== (k + 1) % N) begin
        mismatched++;
        $display("FAIL skip_order%0d: got %0d want %0d",
                 k, out_tag, (k + 1) % N);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_stall();
    int g;
    do_reset();
    req_valid = 4'b0100;
    tick(g);
    req_valid = '0;
    out_ready = 1'b0;
    tick(g);
    req_valid = '1;
    #3;
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || req_ready !== '0) begin
      mismatched++;
      $display("FAIL rst_mid: got v=%b rdy=%b want 0/0000", out_valid, req_ready);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    #1;
    compared++;
    if (req_ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL rst_mid_ready: got %b want 0001", req_ready);
    end
    tick(g);
    req_valid = '0;
    compared++;
    if (out_valid !== 1'b1 || out_tag !== 2'd0) begin
      mismatched++;
      $display("FAIL rst_mid_first: got v=%b t=%0d want 1/0", out_valid, out_tag);
    end
  endtask

  task automatic test_random();
    int g;
    int waitc [N];
    do_reset();
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          set_op(i, $urandom, $urandom, $urandom, $urandom);
          req_valid[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(3, 0) != 0);
      #1;
      compared++;
      if (req_ready !== exp_ready() || busy !== (m_ov || (|req_valid))) begin
        mismatched++;
        $display("FAIL rand_ready c%0d: got rdy=%b busy=%b want %b/%b",
                 c, req_ready, busy, exp_ready(), m_ov || (|req_valid));
      end
      tick(g);
      if (g >= 0) begin
        compared++;
        if (waitc[g] > N - 1) begin
          mismatched++;
          $display("FAIL rand_fair c%0d: req %0d waited %0d want <=%0d",
                   c, g, waitc[g], N - 1);
        end
        waitc[g] = 0;
        for (int i = 0; i < N; i++)
          if (i != g && req_valid[i]) waitc[i]++;
        req_valid[g] = 1'b0;
      end
      compared++;
      if (out_valid !== m_ov || out_sum !== m_sum || int'(out_tag) !== m_tag) begin
        mismatched++;
        $display("FAIL rand_out c%0d: got v=%b s=%h t=%0d want %b/%h/%0d",
                 c, out_valid, out_sum, out_tag, m_ov, m_sum, m_tag);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_pointer_skip();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
